// File: rtl/if_id_decode_stage.sv
// IF/ID register slice with opcode decode to immediate-generator control and field extraction.
// Optional illegal-opcode trap enabled with `define IF_ID_ILLEGAL_TRAP_EN.
module if_id_decode_stage #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      InInstr,
  input  logic [PC_W-1:0]  InPC,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [PC_W-1:0]  OutPC,
  output logic [25:0]      Imm26,
  output logic [2:0]       ImmCtrl,
  output logic [4:0]       Rd,
  output logic [4:0]       Rn,
  output logic [4:0]       Rm,
  output logic [CNT_W-1:0] DecodeCount
`ifdef IF_ID_ILLEGAL_TRAP_EN
  ,
  output logic             Illegal,
  output logic             TrapSticky
`endif
);

  localparam logic [2:0] CtrlImmAlu  = 3'b000;
  localparam logic [2:0] CtrlMem     = 3'b001;
  localparam logic [2:0] CtrlBranch  = 3'b010;
  localparam logic [2:0] CtrlCondBr  = 3'b011;
  localparam logic [2:0] CtrlMovWide = 3'b100;
  localparam logic [2:0] CtrlNone    = 3'b111;

  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, handoff, in_ready_raw;
  logic [2:0]       imm_ctrl;

  assign in_ready_raw = !valid_q || OutReady;

  // Flush drops both the held instruction and any same-cycle arrival.
  assign accept  = InValid && InReady && !Flush;
  assign handoff = valid_q && OutReady && !Flush;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else begin
      if (handoff) begin
        valid_d = 1'b0;
        count_d = count_q + CNT_W'(1);
      end
      if (accept) begin
        valid_d = 1'b1;
        instr_d = InInstr;
        pc_d    = InPC;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    imm_ctrl = CtrlNone;
    if (instr_q[31:22] == 10'b1001000100 || instr_q[31:22] == 10'b1101000100) begin
      imm_ctrl = CtrlImmAlu;
    end else if (instr_q[31:21] == 11'h7C2 || instr_q[31:21] == 11'h7C0) begin
      imm_ctrl = CtrlMem;
    end else if (instr_q[31:26] == 6'b000101) begin
      imm_ctrl = CtrlBranch;
    end else if (instr_q[31:24] == 8'b10110100) begin
      imm_ctrl = CtrlCondBr;
    end else if (instr_q[31:23] == 9'b110100101) begin
      imm_ctrl = CtrlMovWide;
    end
  end

`ifdef IF_ID_ILLEGAL_TRAP_EN
  logic trap_q;

  // R-type data-processing ops carry no immediate but are legal.
  assign Illegal = valid_q && (imm_ctrl == CtrlNone) &&
                   (instr_q[28:24] != 5'b01010) && (instr_q[28:24] != 5'b01011);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      trap_q <= 1'b0;
    end else if (handoff && Illegal) begin
      trap_q <= 1'b1;
    end
  end

  assign TrapSticky = trap_q;
  assign InReady    = in_ready_raw && !trap_q;
`else
  assign InReady = in_ready_raw;
`endif

  assign OutValid    = valid_q;
  assign OutPC       = pc_q;
  assign Imm26       = instr_q[25:0];
  assign ImmCtrl     = imm_ctrl;
  assign Rd          = instr_q[4:0];
  assign Rn          = instr_q[9:5];
  assign Rm          = instr_q[20:16];
  assign DecodeCount = count_q;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Scoreboard bench for if_id_decode_stage: driver pushes expected decodes, monitor pops on hand-off.
module tb_if_id_decode_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  ctrl;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset_L, InValid, InReady, Flush, OutValid, OutReady;
  logic [31:0] InInstr;
  logic [63:0] InPC, OutPC;
  logic [25:0] Imm26;
  logic [2:0]  ImmCtrl;
  logic [4:0]  Rd, Rn, Rm;
  logic [31:0] DecodeCount;
  logic        in_ready4, out_valid4;
  logic [63:0] out_pc4;
  logic [25:0] imm26_4;
  logic [2:0]  imm_ctrl4;
  logic [4:0]  rd4, rn4, rm4;
  logic [3:0]  count4;
`ifdef IF_ID_ILLEGAL_TRAP_EN
  logic        Illegal, TrapSticky, illegal4, trap4;
`endif

  always #5 CLK = ~CLK;

  if_id_decode_stage dut (
    .CLK(CLK), .Reset_L(Reset_L), .InValid(InValid), .InReady(InReady), .InInstr(InInstr),
    .InPC(InPC), .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady), .OutPC(OutPC),
    .Imm26(Imm26), .ImmCtrl(ImmCtrl), .Rd(Rd), .Rn(Rn), .Rm(Rm), .DecodeCount(DecodeCount)
`ifdef IF_ID_ILLEGAL_TRAP_EN
    , .Illegal(Illegal), .TrapSticky(TrapSticky)
`endif
  );

  // Narrow-counter instance on the same stimulus, for the wrap check.
  if_id_decode_stage #(.PC_W(64), .CNT_W(4)) dut4 (
    .CLK(CLK), .Reset_L(Reset_L), .InValid(InValid), .InReady(in_ready4), .InInstr(InInstr),
    .InPC(InPC), .Flush(Flush), .OutValid(out_valid4), .OutReady(OutReady), .OutPC(out_pc4),
    .Imm26(imm26_4), .ImmCtrl(imm_ctrl4), .Rd(rd4), .Rn(rn4), .Rm(rm4), .DecodeCount(count4)
`ifdef IF_ID_ILLEGAL_TRAP_EN
    , .Illegal(illegal4), .TrapSticky(trap4)
`endif
  );

  exp_t        sb[$];
  exp_t        tab[8];
  int          n_vec = 0;
  int          n_fail = 0;
  int          stalls = 0;
  logic [31:0] exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Presents one instruction until accepted; pushes expectation at the accepting edge.
  task automatic send(input exp_t v);
    bit done = 0;
    InValid = 1'b1;
    InInstr = v.instr;
    InPC    = v.pc;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (InReady && !Flush) begin
        sb.push_back(v);
        done = 1;
      end else begin
        stalls++;
      end
      @(posedge CLK);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: compares every counted hand-off against the scoreboard head.
  initial begin
    exp_t e;
    logic [31:0] ins;
    forever begin
      @(negedge CLK);
      if (Reset_L && OutValid) begin
        if (Flush) begin
          if (sb.size() > 0) void'(sb.pop_front());
        end else if (OutReady) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
          end else begin
            e   = sb.pop_front();
            ins = e.instr;
            check("immctrl", 64'(ImmCtrl), 64'(e.ctrl));
            check("imm26", 64'(Imm26), 64'(ins[25:0]));
            check("rd", 64'(Rd), 64'(ins[4:0]));
            check("rn", 64'(Rn), 64'(ins[9:5]));
            check("rm", 64'(Rm), 64'(ins[20:16]));
            check("outpc", OutPC, e.pc);
            check("count", 64'(DecodeCount), 64'(exp_cnt));
            check("count4", 64'(count4), 64'(exp_cnt[3:0]));
            exp_cnt++;
          end
        end
      end
    end
  end

  initial begin
    tab[0] = '{instr: 32'h91000C41, pc: 64'h1000, ctrl: 3'b000};  // ADDI
    tab[1] = '{instr: 32'hF8408041, pc: 64'h1004, ctrl: 3'b001};  // LDUR
    tab[2] = '{instr: 32'h14000010, pc: 64'h1008, ctrl: 3'b010};  // B
    tab[3] = '{instr: 32'hB4000060, pc: 64'h100C, ctrl: 3'b011};  // CBZ
    tab[4] = '{instr: 32'hD2A00020, pc: 64'h1010, ctrl: 3'b100};  // MOVZ
    tab[5] = '{instr: 32'hD1000421, pc: 64'h1014, ctrl: 3'b000};  // SUBI
    tab[6] = '{instr: 32'hF8000041, pc: 64'h1018, ctrl: 3'b001};  // STUR
    tab[7] = '{instr: 32'h8B020020, pc: 64'h101C, ctrl: 3'b111};  // ADD (R-type)

    Reset_L = 1'b0; InValid = 1'b0; InInstr = '0; InPC = '0; Flush = 1'b0; OutReady = 1'b1;
    #1;
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_immctrl", 64'(ImmCtrl), 64'd7);
    check("rst_count", 64'(DecodeCount), 64'd0);
    check("rst_outpc", OutPC, 64'd0);
    @(posedge CLK); @(posedge CLK); #1;
    Reset_L = 1'b1;

    // Back-to-back stream
    stalls = 0;
    for (int i = 0; i < 5; i++) send(tab[i]);
    InValid = 1'b0;
    check("stream_stalls", 64'(stalls), 64'd0);
    @(posedge CLK); #1;
    check("stream_count", 64'(DecodeCount), 64'd5);

    // Backpressure: ADDI held three cycles, then simultaneous hand-off and accept
    OutReady = 1'b0;
    send(tab[0]);
    InValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_inready", 64'(InReady), 64'd0);
      check("bp_immctrl", 64'(ImmCtrl), 64'd0);
      check("bp_outpc", OutPC, 64'h1000);
      check("bp_imm26", 64'(Imm26), 64'h1000C41);
    end
    @(posedge CLK); #1;
    OutReady = 1'b1;
    send(tab[5]);
    InValid = 1'b0;
    @(negedge CLK);
    check("zero_bubble_valid", 64'(OutValid), 64'd1);
    @(posedge CLK); #1;

    // Flush collision: held B discarded, same-cycle MOVZ dropped, count unchanged
    OutReady = 1'b0;
    send(tab[2]);
    Flush = 1'b1; InValid = 1'b1; InInstr = tab[4].instr; InPC = tab[4].pc; OutReady = 1'b1;
    @(negedge CLK);
    check("flush_inready", 64'(InReady), 64'd1);
    @(posedge CLK); #1;
    Flush = 1'b0; InValid = 1'b0;
    @(negedge CLK);
    check("flush_outvalid", 64'(OutValid), 64'd0);
    check("flush_count", 64'(DecodeCount), 64'd7);
    check("flush_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge CLK); #1;

    // Asynchronous reset mid-cycle with an instruction held
    OutReady = 1'b0;
    send(tab[3]);
    InValid = 1'b0;
    #1 Reset_L = 1'b0;
    #1;
    check("async_outvalid", 64'(OutValid), 64'd0);
    check("async_count", 64'(DecodeCount), 64'd0);
    check("async_immctrl", 64'(ImmCtrl), 64'd7);
    check("async_outpc", OutPC, 64'd0);
    check("async_rd", 64'(Rd), 64'd0);
    sb.delete();
    exp_cnt = 0;
    #1 Reset_L = 1'b1;
    OutReady = 1'b1;
    @(posedge CLK); #1;

    // Counter wrap on the 4-bit instance: 17 hand-offs
    for (int i = 0; i < 17; i++) send(tab[i % 8]);
    InValid = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("wrap_count32", 64'(DecodeCount), 64'd17);
    check("wrap_count4", 64'(count4), 64'd1);

`ifdef IF_ID_ILLEGAL_TRAP_EN
    @(posedge CLK); #1;
    OutReady = 1'b0;
    send('{instr: 32'h0, pc: 64'h2000, ctrl: 3'b111});
    InValid = 1'b0;
    @(negedge CLK);
    check("illegal", 64'(Illegal), 64'd1);
    @(posedge CLK); #1;
    OutReady = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("trap_sticky", 64'(TrapSticky), 64'd1);
    check("trap_inready", 64'(InReady), 64'd0);
`endif

    @(posedge CLK); #1;
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
